operand_fetch_sb: RTL and testbench

- Decode-to-execute operand fetch stage with a register scoreboard, sitting directly upstream of the 16 x 32 dual-port register file.
- Takes one decoded instruction per cycle and drives both register-file read addresses.
- Forwards the same-cycle writeback result and stalls on RAW/WAW hazards using per-register busy bits.
- Presents operands to execute through a one-entry valid/ready output register.

---
 rtl/operand_fetch_sb.sv | 111 +++++++++++
 tb/tb_operand_fetch_sb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_sb.sv
// Operand fetch stage with a per-register busy scoreboard, same-cycle writeback
// forwarding and a one-entry valid/ready output register toward execute.
module operand_fetch_sb #(
  parameter int NREGS = 16,
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int OPW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [AW-1:0]  in_rs0,
  input  logic [AW-1:0]  in_rs1,
  input  logic [AW-1:0]  in_rd,
  input  logic           in_rd_en,
  output logic [AW-1:0]  rf_addr0,
  output logic [AW-1:0]  rf_addr1,
  input  logic [DW-1:0]  rf_data0,
  input  logic [DW-1:0]  rf_data1,
  input  logic           wb_valid,
  input  logic [AW-1:0]  wb_addr,
  input  logic [DW-1:0]  wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OPW-1:0] out_op,
  output logic [AW-1:0]  out_rd,
  output logic           out_rd_en,
  output logic [DW-1:0]  out_a,
  output logic [DW-1:0]  out_b,
  output logic           sb_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [NREGS-1:0] busy, busy_nxt;
  logic [NREGS-1:0] wb_hot, set_hot, ebusy;
  logic             hazard, issue, sb_err_nxt;
  logic [DW-1:0]    op_a, op_b;

  assign rf_addr0 = in_rs0;
  assign rf_addr1 = in_rs1;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wb_hot  = '0;
    set_hot = '0;
    if (wb_valid) wb_hot[wb_addr] = 1'b1;
    if (issue && in_rd_en) set_hot[in_rd] = 1'b1;
  end

  // A register being written back this cycle is no longer a hazard.
  assign ebusy  = busy & ~wb_hot;
  assign hazard = in_valid && (ebusy[in_rs0] || ebusy[in_rs1] || (in_rd_en && ebusy[in_rd]));

  assign out_valid = (state == FULL);
  assign in_ready  = !hazard && (!out_valid || out_ready);
  assign issue     = in_valid && in_ready;

  assign op_a = (wb_valid && wb_addr == in_rs0) ? wb_data : rf_data0;
  assign op_b = (wb_valid && wb_addr == in_rs1) ? wb_data : rf_data1;

  // Set is applied after clear so an issuing writer keeps its destination busy.
  assign busy_nxt   = (busy & ~wb_hot) | set_hot;
  assign sb_err_nxt = sb_err | (wb_valid && !busy[wb_addr]);

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (issue) state_nxt = FULL;
      FULL:    if (!issue && out_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy   <= busy_nxt;
      sb_err <= sb_err_nxt;
    end
  end

  // NOTE: the output data registers are reset too, so execute never sees stale X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_op    <= '0;
      out_rd    <= '0;
      out_rd_en <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
    end else if (issue) begin
      out_op    <= in_op;
      out_rd    <= in_rd;
      out_rd_en <= in_rd_en;
      out_a     <= op_a;
      out_b     <= op_b;
    end
  end

endmodule

// File: tb/tb_operand_fetch_sb.sv
// Self-checking bench for operand_fetch_sb: directed hazard/backpressure/reset
// scenarios followed by randomized traffic, checked by a scoreboard against a reference model.
module tb_operand_fetch_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rd_en;
  logic [7:0]  in_op;
  logic [3:0]  in_rs0, in_rs1, in_rd;
  logic [3:0]  rf_addr0, rf_addr1;
  logic [31:0] rf_data0, rf_data1;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready, out_rd_en, sb_err;
  logic [7:0]  out_op;
  logic [3:0]  out_rd;
  logic [31:0] out_a, out_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic        rd_en;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rf_mem[16];
  bit          m_busy[16];
  bit          m_full;
  bit          m_sberr;
  bit          m_accept;

  always #5 clk = ~clk;

  assign rf_data0 = rf_mem[rf_addr0];
  assign rf_data1 = rf_mem[rf_addr1];

  operand_fetch_sb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_rd_en(in_rd_en),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1), .rf_data0(rf_data0), .rf_data1(rf_data1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_rd(out_rd),
    .out_rd_en(out_rd_en), .out_a(out_a), .out_b(out_b), .sb_err(sb_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A register still blocks only if it is busy and not being written back right now.
  function automatic bit still_busy(input logic [3:0] r);
    return m_busy[r] && !(wb_valid && wb_addr == r);
  endfunction

  function automatic bit model_ready();
    bit hz;
    hz = in_valid && (still_busy(in_rs0) || still_busy(in_rs1) || (in_rd_en && still_busy(in_rd)));
    return !hz && (!m_full || out_ready);
  endfunction

  // Reference model: decides acceptance from the current inputs and pushes the expected result.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
      m_full   = 1'b0;
      m_sberr  = 1'b0;
      m_accept = 1'b0;
      exp_q.delete();
    end else begin
      exp_t e;
      bit   acc;
      acc = in_valid && model_ready();
      if (acc) begin
        e.op    = in_op;
        e.rd    = in_rd;
        e.rd_en = in_rd_en;
        e.a     = (wb_valid && wb_addr == in_rs0) ? wb_data : rf_mem[in_rs0];
        e.b     = (wb_valid && wb_addr == in_rs1) ? wb_data : rf_mem[in_rs1];
        exp_q.push_back(e);
      end
      m_full = acc || (m_full && !out_ready);
      if (wb_valid) begin
        if (!m_busy[wb_addr]) m_sberr = 1'b1;
        m_busy[wb_addr] = 1'b0;
        rf_mem[wb_addr] <= wb_data;
      end
      if (acc && in_rd_en) m_busy[in_rd] = 1'b1;
      m_accept = acc;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("rf_addr0", rf_addr0, in_rs0);
      check("rf_addr1", rf_addr1, in_rs1);
      check("in_ready", in_ready, model_ready());
      check("out_valid", out_valid, m_full);
      check("sb_err", sb_err, m_sberr);
      if (out_valid && exp_q.size() > 0) begin
        check("out_op", out_op, exp_q[0].op);
        check("out_rd", out_rd, exp_q[0].rd);
        check("out_rd_en", out_rd_en, exp_q[0].rd_en);
        check("out_a", out_a, exp_q[0].a);
        check("out_b", out_b, exp_q[0].b);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] op, input logic [3:0] r0,
                     input logic [3:0] r1, input logic [3:0] rd, input logic rde,
                     input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                     input logic ordy);
    in_valid = v;  in_op = op;  in_rs0 = r0;  in_rs1 = r1;
    in_rd = rd;    in_rd_en = rde;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 16; r++) rf_mem[r] = $urandom;
    rf_mem[1] = 32'hA;
    rf_mem[2] = 32'hB;
    rst = 1'b1;
    in_valid = 0; in_op = 0; in_rs0 = 0; in_rs1 = 0; in_rd = 0; in_rd_en = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_a", out_a, 32'h0);
    check("reset sb_err", sb_err, 1'b0);
    rst = 1'b0;

    // Basic issue with one-cycle latency.
    cyc(1, 8'h11, 4'd1, 4'd2, 4'd3, 1, 0, 4'd0, 32'h0, 1);
    check("t1 out_valid", out_valid, 1'b1);
    check("t1 out_a", out_a, 32'hA);
    check("t1 out_b", out_b, 32'hB);
    check("t1 out_rd", out_rd, 4'd3);

    // RAW on r3: stall, then forwarded writeback releases it.
    cyc(1, 8'h22, 4'd3, 4'd0, 4'd4, 0, 0, 4'd0, 32'h0, 1);
    cyc(1, 8'h22, 4'd3, 4'd0, 4'd4, 0, 1, 4'd3, 32'h55, 1);
    check("t2 out_op", out_op, 8'h22);
    check("t2 forwarded out_a", out_a, 32'h55);

    // WAW on r5: set wins over the same-edge clear.
    cyc(1, 8'h33, 4'd0, 4'd0, 4'd5, 1, 0, 4'd0, 32'h0, 1);
    cyc(1, 8'h34, 4'd0, 4'd0, 4'd5, 1, 0, 4'd0, 32'h0, 1);
    cyc(1, 8'h34, 4'd0, 4'd0, 4'd5, 1, 1, 4'd5, 32'h77, 1);
    check("t3 out_op", out_op, 8'h34);
    cyc(0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 1, 4'd5, 32'h78, 1);
    check("t3 busy5 kept", sb_err, 1'b0);

    // Backpressure: output holds for three cycles, then advances.
    cyc(1, 8'h44, 4'd1, 4'd2, 4'd6, 0, 0, 4'd0, 32'h0, 0);
    repeat (3) cyc(1, 8'h45, 4'd2, 4'd1, 4'd8, 1, 0, 4'd0, 32'h0, 0);
    check("t4 held out_op", out_op, 8'h44);
    cyc(1, 8'h45, 4'd2, 4'd1, 4'd8, 1, 0, 4'd0, 32'h0, 1);
    check("t4 advanced out_op", out_op, 8'h45);

    // Writeback to a non-busy register flags a sticky error.
    cyc(0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 1, 4'd7, 32'h99, 1);
    check("t5 sb_err set", sb_err, 1'b1);
    repeat (2) cyc(0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 32'h0, 1);
    check("t5 sb_err sticky", sb_err, 1'b1);

    // Asynchronous reset while full with r3 busy.
    cyc(1, 8'h66, 4'd0, 4'd0, 4'd3, 1, 0, 4'd0, 32'h0, 0);
    cyc(0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 32'h0, 0);
    #2 rst = 1'b1;
    #1;
    check("t6 out_valid cleared", out_valid, 1'b0);
    check("t6 out_op cleared", out_op, 8'h0);
    check("t6 sb_err cleared", sb_err, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 8'h67, 4'd3, 4'd3, 4'd9, 0, 0, 4'd0, 32'h0, 1);
    check("t6 post-reset out_op", out_op, 8'h67);
    check("t6 post-reset out_a", out_a, 32'h55);
    check("t6 post-reset out_b", out_b, 32'h55);

    // Randomized traffic; stalled instructions are held stable.
    for (int i = 0; i < 3000; i++) begin
      logic        v, rde, wv, ordy;
      logic [7:0]  op;
      logic [3:0]  r0, r1, rd, wa;
      logic [31:0] wd;
      int          cand[$];
      if (in_valid && !m_accept) begin
        v = in_valid; op = in_op; r0 = in_rs0; r1 = in_rs1; rd = in_rd; rde = in_rd_en;
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        op  = 8'($urandom);
        r0  = 4'($urandom_range(0, 7));
        r1  = 4'($urandom_range(0, 7));
        rd  = 4'($urandom_range(0, 7));
        rde = ($urandom_range(0, 2) != 0);
      end
      wv = 1'b0; wa = 4'd0; wd = $urandom;
      for (int r = 0; r < 16; r++) if (m_busy[r]) cand.push_back(r);
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        wv = 1'b1;
        wa = 4'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      ordy = ($urandom_range(0, 3) != 0);
      cyc(v, op, r0, r1, rd, rde, wv, wa, wd, ordy);
    end

    repeat (2) cyc(0, 8'h00, 4'd0, 4'd0, 4'd0, 0, 0, 4'd0, 32'h0, 1);
    check("drain queue empty", 64'(exp_q.size()), 64'd0);
    check("drain out_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
